// File: rtl/entry_alloc_arbiter_pkg.sv
// Shared types and sizing for the entry allocation arbiter and its round-robin picker.
// Also holds the grant-limit helper used by the top level.
package entry_alloc_arbiter_pkg;

   localparam int REQ_NUM     = 4;
   localparam int ALLOC_WIDTH = 2;
   localparam int ENTRY_COUNT = 8;
   localparam int FLAG_EN     = 0;
   localparam int TAG_WIDTH   = $clog2(ENTRY_COUNT) + FLAG_EN;
   localparam int CNT_WIDTH   = $clog2(ENTRY_COUNT + 1);
   localparam int PTR_WIDTH   = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
   localparam int LANE_WIDTH  = (ALLOC_WIDTH > 1) ? $clog2(ALLOC_WIDTH) : 1;
   localparam int GRANT_WIDTH = $clog2(ALLOC_WIDTH + 1);
   localparam int POP_WIDTH   = $clog2(REQ_NUM + 1);

   typedef logic [TAG_WIDTH-1:0] tag_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BLOCK   = 2'd1,
      FLUSH   = 2'd2,
      RECOVER = 2'd3
   } flush_state_e;

   // Smallest of lane count, free entries and live requests; all compared zero-extended.
   function automatic logic [GRANT_WIDTH-1:0] grantLimit(
      input logic [CNT_WIDTH-1:0] avail,
      input logic [POP_WIDTH-1:0] reqCount
   );
      logic [GRANT_WIDTH-1:0] r;
      r = GRANT_WIDTH'(ALLOC_WIDTH);
      if (32'(avail) < 32'(r)) r = GRANT_WIDTH'(avail);
      if (32'(reqCount) < 32'(r)) r = GRANT_WIDTH'(reqCount);
      return r;
   endfunction

endpackage

// File: rtl/entry_alloc_arbiter_if.sv
// Requester and pool-facing signal bundle of the entry allocation arbiter.
// The slave modport is the arbiter's view; master is the surrounding logic.
interface entry_alloc_arbiter_if;
   import entry_alloc_arbiter_pkg::*;

   logic [REQ_NUM-1:0]               req_valid_i;
   logic [REQ_NUM-1:0]               req_ready_o;
   logic [REQ_NUM*TAG_WIDTH-1:0]     req_tag_o;
   logic [ALLOC_WIDTH*TAG_WIDTH-1:0] pool_tail_i;
   logic [CNT_WIDTH-1:0]             pool_avail_cnt_i;
   logic [ALLOC_WIDTH-1:0]           pool_enq_fire_o;
   logic                             pool_flush_o;
   logic                             flush_req_i;
   logic                             flush_busy_o;
   logic                             flush_done_o;

   modport slave (
      input  req_valid_i, pool_tail_i, pool_avail_cnt_i, flush_req_i,
      output req_ready_o, req_tag_o, pool_enq_fire_o, pool_flush_o,
             flush_busy_o, flush_done_o
   );

   modport master (
      output req_valid_i, pool_tail_i, pool_avail_cnt_i, flush_req_i,
      input  req_ready_o, req_tag_o, pool_enq_fire_o, pool_flush_o,
             flush_busy_o, flush_done_o
   );
endinterface

// File: rtl/entry_alloc_arbiter_picker.sv
// Combinational round-robin picker: grants the first i_limit valid requesters from i_ptr onward,
// assigning each one the next free lane in scan order.
module rr_multi_picker
   import entry_alloc_arbiter_pkg::*;
(
   input  logic [REQ_NUM-1:0]                  i_req,
   input  logic [PTR_WIDTH-1:0]                i_ptr,
   input  logic [GRANT_WIDTH-1:0]              i_limit,
   output logic [REQ_NUM-1:0]                  o_grant,
   output logic [REQ_NUM-1:0][LANE_WIDTH-1:0]  o_lane,
   output logic [PTR_WIDTH-1:0]                o_last
);

   always_comb begin
      logic [GRANT_WIDTH-1:0] count;
      logic [PTR_WIDTH:0]     idxWide;
      logic [PTR_WIDTH-1:0]   idx;
      o_grant = '0;
      o_lane  = '0;
      o_last  = i_ptr;
      count   = '0;
      idxWide = '0;
      idx     = '0;
      for (int i = 0; i < REQ_NUM; i++) begin
         // Wrap explicitly so non-power-of-two requester counts still scan correctly.
         idxWide = {1'b0, i_ptr} + (PTR_WIDTH+1)'(i);
         if (idxWide >= (PTR_WIDTH+1)'(REQ_NUM)) idxWide = idxWide - (PTR_WIDTH+1)'(REQ_NUM);
         idx = idxWide[PTR_WIDTH-1:0];
         if (i_req[idx] && (count < i_limit)) begin
            o_grant[idx] = 1'b1;
            o_lane[idx]  = count[LANE_WIDTH-1:0];
            o_last       = idx;
            count        = count + 1'b1;
         end
      end
   end

endmodule

// File: rtl/entry_alloc_arbiter.sv
// Round-robin allocator over a shared free-entry pool, with a four-state flush sequencer
// that blocks grants while the pool is flushed and refilled.
module entry_alloc_arbiter
   import entry_alloc_arbiter_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   entry_alloc_arbiter_if.slave  bus
);

   flush_state_e                        r_state;
   logic [PTR_WIDTH-1:0]                r_rrPtr;
   logic                                r_poolFlush;
   logic                                r_flushDone;
   logic                                r_flushBusy;
   logic                                w_grantAllowed;
   logic [POP_WIDTH-1:0]                w_reqCount;
   logic [GRANT_WIDTH-1:0]              w_limit;
   logic [REQ_NUM-1:0]                  w_grant;
   logic [REQ_NUM-1:0][LANE_WIDTH-1:0]  w_lane;
   logic [PTR_WIDTH-1:0]                w_last;
   logic [REQ_NUM*TAG_WIDTH-1:0]        w_tags;
   logic [ALLOC_WIDTH-1:0]              w_fire;

   assign w_grantAllowed = !rst && (r_state == IDLE) && !bus.flush_req_i;

   always_comb begin
      w_reqCount = '0;
      for (int i = 0; i < REQ_NUM; i++) begin
         w_reqCount = w_reqCount + POP_WIDTH'(bus.req_valid_i[i]);
      end
      w_limit = w_grantAllowed ? grantLimit(bus.pool_avail_cnt_i, w_reqCount) : '0;
   end

   rr_multi_picker u_picker (
      .i_req   (bus.req_valid_i),
      .i_ptr   (r_rrPtr),
      .i_limit (w_limit),
      .o_grant (w_grant),
      .o_lane  (w_lane),
      .o_last  (w_last)
   );

   // Lane k fires exactly when at least k+1 grants were made, keeping fires contiguous from lane 0.
   always_comb begin
      w_tags = '0;
      w_fire = '0;
      for (int r = 0; r < REQ_NUM; r++) begin
         for (int k = 0; k < ALLOC_WIDTH; k++) begin
            if (w_grant[r] && (w_lane[r] == LANE_WIDTH'(k))) begin
               w_tags[r*TAG_WIDTH +: TAG_WIDTH] = bus.pool_tail_i[k*TAG_WIDTH +: TAG_WIDTH];
            end
         end
      end
      for (int k = 0; k < ALLOC_WIDTH; k++) begin
         w_fire[k] = (GRANT_WIDTH'(k) < w_limit);
      end
   end

   assign bus.req_ready_o     = w_grant;
   assign bus.req_tag_o       = w_tags;
   assign bus.pool_enq_fire_o = w_fire;
   assign bus.pool_flush_o    = r_poolFlush && !rst;
   assign bus.flush_done_o    = r_flushDone && !rst;
   assign bus.flush_busy_o    = r_flushBusy && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rrPtr <= '0;
      end else if (w_limit != '0) begin
         r_rrPtr <= (w_last == PTR_WIDTH'(REQ_NUM - 1)) ? '0 : w_last + 1'b1;
      end
   end

   // Flag outputs are set on entry to the state they describe so they line up with it exactly.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_poolFlush <= 1'b0;
         r_flushDone <= 1'b0;
         r_flushBusy <= 1'b0;
      end else begin
         r_poolFlush <= 1'b0;
         r_flushDone <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.flush_req_i) begin
                  r_state     <= BLOCK;
                  r_flushBusy <= 1'b1;
               end
            end
            BLOCK: begin
               r_state     <= FLUSH;
               r_poolFlush <= 1'b1;
            end
            FLUSH: begin
               r_state     <= RECOVER;
               r_flushDone <= 1'b1;
            end
            RECOVER: begin
               r_state     <= IDLE;
               r_flushBusy <= 1'b0;
            end
            default: begin
               r_state     <= IDLE;
               r_flushBusy <= 1'b0;
            end
         endcase
      end
   end

endmodule
